// File: rtl/audio_pkg.sv
// Shared audio types, FSM encoding and accumulator sizing for the RC mixer.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IN = 2'd1,
    ACC_FB = 2'd2
  } mix_state_e;

  // Headroom for the weighted sum of all channels plus one sign bit for the feedback difference.
  function automatic int acc_width(input int in_w, input int channels, input logic [31:0] shifts);
    int sum;
    sum = 0;
    for (int i = 0; i < channels; i++) begin
      sum += (1 << shifts[i*4 +: 4]);
    end
    return in_w + $clog2(sum) + 1;
  endfunction

endpackage

// File: rtl/rc_mixer_n_sat_trunc.sv
// Width reduction of the mixer output: clamp with clip flag when RC_MIXER_SAT_EN
// is defined, otherwise two's-complement wrap with clip tied low.
module sat_trunc #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  if (IN_W <= OUT_W) begin : g_widen
    assign dout = OUT_W'(din);
    assign clip = 1'b0;
  end else begin : g_narrow
`ifdef RC_MIXER_SAT_EN
    // Returns {clip, value}; in range when all bits above the output sign agree.
    function automatic logic [OUT_W:0] saturate(input logic signed [IN_W-1:0] v);
      logic [IN_W-OUT_W:0] hi;
      hi = v[IN_W-1:OUT_W-1];
      if (&hi || ~|hi) return {1'b0, v[OUT_W-1:0]};
      return {1'b1, v[IN_W-1], {(OUT_W-1){~v[IN_W-1]}}};
    endfunction

    assign {clip, dout} = saturate(din);
`else
    logic unused_hi;
    assign unused_hi = ^din[IN_W-1:OUT_W];
    assign dout      = din[OUT_W-1:0];
    assign clip      = 1'b0;
`endif
  end

endmodule

// File: rtl/rc_mixer_n.sv
// N-channel weighted mixer with forward-Euler RC low-pass, one shared adder,
// one weighted term per cycle. Output saturation selected by RC_MIXER_SAT_EN.
module rc_mixer_n
  import audio_pkg::*;
#(
  parameter int                       CHANNELS     = 3,
  parameter int                       IN_W         = 16,
  parameter int                       OUT_W        = 16,
  parameter logic [CHANNELS-1:0][3:0] WEIGHT_SHIFT = {4'd1, 4'd0, 4'd0},
  parameter int                       DELTA_SHIFT  = 7,
  parameter int                       OUT_SHIFT    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_en,
  input  logic [CHANNELS*IN_W-1:0] sound_in,
  output logic signed [OUT_W-1:0]  sound_out,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun
);

  localparam int ACC_W  = acc_width(IN_W, CHANNELS, 32'(WEIGHT_SHIFT));
  localparam int FULL_W = ACC_W + OUT_SHIFT;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHANNELS - 1);

  mix_state_e cur, nxt;
  logic                     accept;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  state, slope, state_nxt;
  logic signed [ACC_W-1:0]  snap [CHANNELS];
  logic signed [ACC_W-1:0]  operand, term, acc_sum;
  logic [3:0]               wsh;
  logic signed [FULL_W-1:0] full;
  logic signed [OUT_W-1:0]  sat_out;
  logic                     sat_clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (sample_en)   nxt = ACC_IN;
      ACC_IN:  if (idx == LAST) nxt = ACC_FB;
      ACC_FB:  if (idx == LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (cur != IDLE);
    accept = (cur == IDLE) && sample_en;
  end

  // Shared adder: input terms add, feedback terms (current state) subtract.
  always_comb begin
    operand = state;
    wsh     = 4'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx == IDX_W'(i)) begin
        wsh = WEIGHT_SHIFT[i];
        if (cur == ACC_IN) operand = snap[i];
      end
    end
    term    = operand <<< wsh;
    acc_sum = (cur == ACC_IN) ? (slope + term) : (slope - term);
  end

  assign state_nxt = state + (slope >>> DELTA_SHIFT);
  assign full      = FULL_W'(state_nxt) <<< OUT_SHIFT;

  sat_trunc #(
    .IN_W  (FULL_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din  (full),
    .dout (sat_out),
    .clip (sat_clip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      slope     <= '0;
      idx       <= '0;
      sound_out <= '0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) snap[i] <= '0;
    end else begin
      if (sample_en && busy) overrun <= 1'b1;
      case (cur)
        IDLE: begin
          if (accept) begin
            state     <= state_nxt;
            slope     <= '0;
            idx       <= '0;
            sound_out <= sat_out;
            clip      <= sat_clip;
            for (int i = 0; i < CHANNELS; i++) begin
              snap[i] <= ACC_W'($signed(sound_in[i*IN_W +: IN_W]));
            end
          end
        end
        ACC_IN, ACC_FB: begin
          slope <= acc_sum;
          idx   <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_mixer_n.sv
// Directed bench for rc_mixer_n: default 3-channel instance plus a 4-channel weighted instance.
module tb_rc_mixer_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_en_a = 1'b0, sample_en_b = 1'b0;
  logic [47:0] sound_in_a = '0;
  logic [63:0] sound_in_b = '0;
  logic signed [15:0] sound_out_a, sound_out_b;
  logic busy_a, clip_a, overrun_a, busy_b, clip_b, overrun_b;

  int tests = 0;
  int fails = 0;
  longint ms_a = 0, sl_a = 0, ms_b = 0, sl_b = 0;

  always #5 clk = ~clk;

  rc_mixer_n dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en_a),
    .sound_in  (sound_in_a),
    .sound_out (sound_out_a),
    .busy      (busy_a),
    .clip      (clip_a),
    .overrun   (overrun_a)
  );

  rc_mixer_n #(
    .CHANNELS     (4),
    .WEIGHT_SHIFT ({4'd2, 4'd0, 4'd0, 4'd0})
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en_b),
    .sound_in  (sound_in_b),
    .sound_out (sound_out_b),
    .busy      (busy_b),
    .clip      (clip_b),
    .overrun   (overrun_b)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint out_of(input longint s);
    longint full;
    full = s * 4;
`ifdef RC_MIXER_SAT_EN
    if (full > 32767)  return 32767;
    if (full < -32768) return -32768;
    return full;
`else
    begin
      logic signed [15:0] w;
      w = full[15:0];
      return longint'(w);
    end
`endif
  endfunction

  function automatic longint clip_of(input longint s);
`ifdef RC_MIXER_SAT_EN
    return ((s * 4 > 32767) || (s * 4 < -32768)) ? 1 : 0;
`else
    return (s == s + 1) ? 1 : 0;
`endif
  endfunction

  // Reference: weights 2,1,1 (ch2..ch0); slope is built from the freshly updated state.
  task automatic model_a(input longint x0, input longint x1, input longint x2);
    ms_a = ms_a + (sl_a >>> 7);
    sl_a = 2 * x2 + x1 + x0 - 4 * ms_a;
  endtask

  // Reference: weights 4,1,1,1 (ch3..ch0).
  task automatic model_b(input longint x3);
    ms_b = ms_b + (sl_b >>> 7);
    sl_b = 4 * x3 - 7 * ms_b;
  endtask

  // Called on a falling edge; returns on the falling edge where the next strobe may start.
  // dup>0 raises sample_en again before the dup-th rising edge after the accepted one.
  task automatic strobe_a(input int x0, input int x1, input int x2, input int dup, input bit chk_busy);
    sound_in_a  = {16'(x2), 16'(x1), 16'(x0)};
    sample_en_a = 1'b1;
    model_a(x0, x1, x2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      sample_en_a = (k == dup);
      sound_in_a  = 48'({$urandom(), $urandom()});
      if (k == 1) begin
        check("out_a", sound_out_a, out_of(ms_a));
        check("clip_a", clip_a, clip_of(ms_a));
      end
      if (chk_busy && (k == 1 || k == 6)) check("busy_hi", busy_a, 1);
      if (chk_busy && k == 7) check("busy_lo", busy_a, 0);
    end
    sample_en_a = 1'b0;
  endtask

  task automatic strobe_b(input int x3);
    sound_in_b  = {16'(x3), 48'(0)};
    sample_en_b = 1'b1;
    model_b(x3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sample_en_b = 1'b0;
      sound_in_b  = 64'({$urandom(), $urandom()});
      if (k == 1) begin
        check("out_b", sound_out_b, out_of(ms_b));
        check("clip_b", clip_b, clip_of(ms_b));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) begin
      @(negedge clk);
      sample_en_a = ~sample_en_a;
      sample_en_b = ~sample_en_b;
      sound_in_a  = 48'({$urandom(), $urandom()});
      sound_in_b  = 64'({$urandom(), $urandom()});
    end
    check("rst_out_a", sound_out_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_clip_a", clip_a, 0);
    check("rst_ovr_a", overrun_a, 0);
    check("rst_out_b", sound_out_b, 0);
    check("rst_ovr_b", overrun_b, 0);
    @(negedge clk);
    sample_en_a = 1'b0;
    sample_en_b = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    strobe_a(10000, 10000, 10000, 0, 1'b1);
    check("step1", sound_out_a, 0);
    strobe_a(10000, 10000, 10000, 0, 1'b1);
    check("step2", sound_out_a, 1248);
    check("no_ovr", overrun_a, 0);
    repeat (600) strobe_a(10000, 10000, 10000, 0, 1'b0);
`ifdef RC_MIXER_SAT_EN
    check("sat_out", sound_out_a, 32767);
    check("sat_clip", clip_a, 1);
`else
    check("wrap_neg", sound_out_a[15], 1);
    check("wrap_clip", clip_a, 0);
`endif

    // Abort a calculation with reset on its second busy cycle.
    sound_in_a  = {3{16'sd10000}};
    sample_en_a = 1'b1;
    @(negedge clk);
    sample_en_a = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out", sound_out_a, 0);
    check("mid_busy", busy_a, 0);
    check("mid_clip", clip_a, 0);
    check("mid_ovr", overrun_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ms_a = 0; sl_a = 0; ms_b = 0; sl_b = 0;
    @(negedge clk);
    strobe_a(10000, 10000, 10000, 0, 1'b1);
    check("post_rst1", sound_out_a, 0);
    strobe_a(10000, 10000, 10000, 0, 1'b0);
    check("post_rst2", sound_out_a, 1248);

    strobe_a(1000, 2000, -3000, 3, 1'b1);
    check("ovr_set", overrun_a, 1);
    strobe_a(1000, 2000, -3000, 0, 1'b0);
    strobe_a(-7000, 4000, 5000, 0, 1'b0);
    strobe_a(-7000, 4000, 5000, 0, 1'b0);
    check("ovr_sticky", overrun_a, 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("ovr_rst", overrun_a, 0);
    rst_n = 1'b1;
    ms_a = 0; sl_a = 0;
    @(negedge clk);
    strobe_a(500, 500, 500, 6, 1'b1);
    check("ovr_last_fb", overrun_a, 1);
    strobe_a(500, 500, 500, 0, 1'b0);
    strobe_a(500, 500, 500, 0, 1'b0);

    repeat (600) strobe_b(-8000);
    check("wt_conv", (sound_out_b >= -18288 && sound_out_b <= -18280), 1);
    check("wt_ovr", overrun_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
